// File: rtl/sp_issue_ctrl.sv
// Issue/hazard controller for the single-precision (even) pipe: RAW/WAW scoreboard and dispatch strobe.
// Optional stall statistics counter enabled by defining SP_ISSUE_STATS_EN.
module sp_issue_ctrl #(
  parameter int unsigned FP_LAT  = 6,
  parameter int unsigned INT_LAT = 7,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_int,
  input  logic              issue_reg_write,
  input  logic [ADDR_W-1:0] issue_rt_addr,
  input  logic [ADDR_W-1:0] issue_ra_addr,
  input  logic [ADDR_W-1:0] issue_rb_addr,
  input  logic [ADDR_W-1:0] issue_rc_addr,
  input  logic              issue_ra_used,
  input  logic              issue_rb_used,
  input  logic              issue_rc_used,
  input  logic              flush,
  output logic              issue_ready,
  output logic              dispatch,
  output logic              busy,
  output logic [15:0]       stall_count
);

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic              valid;
    logic              is_int;
    logic [ADDR_W-1:0] rt;
  } slot_t;

  slot_t slot_q [INT_LAT];
  slot_t slot_d [INT_LAT];
  logic  busy_q, busy_d;
  logic  raw_c, waw_c;

  // Slot i holds an entry of age i+1; only entries younger than their latency can cause hazards.
  always_comb begin
    raw_c = 1'b0;
    waw_c = 1'b0;
    for (int unsigned i = 0; i < INT_LAT; i++) begin
      if (slot_q[i].valid && (i + 1 < (slot_q[i].is_int ? INT_LAT : FP_LAT))) begin
        if ((issue_ra_used && issue_ra_addr == slot_q[i].rt) ||
            (issue_rb_used && issue_rb_addr == slot_q[i].rt) ||
            (issue_rc_used && issue_rc_addr == slot_q[i].rt))
          raw_c = 1'b1;
        if (issue_reg_write && issue_rt_addr == slot_q[i].rt &&
            ((issue_is_int ? INT_LAT : FP_LAT) + i + 1 <= (slot_q[i].is_int ? INT_LAT : FP_LAT)))
          waw_c = 1'b1;
      end
    end
  end

  assign issue_ready = ~(raw_c | waw_c);
  assign dispatch    = issue_valid & issue_ready & ~flush;

  always_comb begin
    for (int unsigned i = 0; i < INT_LAT; i++) slot_d[i] = '0;
    busy_d = 1'b0;
    if (!flush) begin
      if (dispatch && issue_reg_write) begin
        slot_d[0].valid  = 1'b1;
        slot_d[0].is_int = issue_is_int;
        slot_d[0].rt     = issue_rt_addr;
      end
      for (int unsigned i = 1; i < INT_LAT; i++) slot_d[i] = slot_q[i-1];
    end
    for (int unsigned i = 0; i < INT_LAT; i++) busy_d = busy_d | slot_d[i].valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < INT_LAT; i++) slot_q[i] <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < INT_LAT; i++) slot_q[i] <= slot_d[i];
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

`ifdef SP_ISSUE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles an instruction is held back by a hazard; saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid && !issue_ready && !flush && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
